delay_tap_ctrl: RTL and testbench
=================================

Name: delay_tap_ctrl

Overview:
- Sequencer for the 16-tap increment-only variable delay line (var_delay15).
- Accepts a target tap value over a valid/ready handshake and issues the required number of single-cycle inc_pulse strobes, with a settle gap between strobes.
- Keeps a shadow copy of the current tap, wrapping 15->0.
- Sits between the calibration/config logic and the delay line; it is the only block that drives inc_pulse.

Parameters:
- TAP_W, 4, tap index width; the delay line has 2**TAP_W taps.
- GAP, 6, idle cycles between consecutive inc_pulse strobes. Legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tgt_valid  in  1  target tap request valid
- tgt_tap  in  TAP_W  requested tap index
- tgt_ready  out  1  controller can accept a target
- tap_clr  in  1  delay line was reset externally; zero the shadow tap
- inc_pulse  out  1  increment strobe to the delay line, one cycle wide
- tap_cur  out  TAP_W  shadow of the delay line's current tap
- busy  out  1  stepping in progress
- done  out  1  one-cycle pulse when the target is reached

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - inc_pulse=0, tap_cur=0, busy=0, done=0, tgt_ready=1 once rst_n deasserts.
  - Internal counters are 0.
- FSM states: IDLE, PULSE, GAP, FIN.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid&tgt_ready, latch rem = (tgt_tap - tap_cur) mod 2**TAP_W (TAP_W-bit wrap subtraction).
  - If rem==0, go to FIN. Otherwise go to PULSE and set busy=1.
- PULSE:
  - inc_pulse=1 for exactly this cycle.
  - At the end of the cycle: tap_cur += 1 (wraps 15->0), rem -= 1, gap counter loaded with GAP.
  - Next state is GAP.
- GAP:
  - inc_pulse=0; gap counter decrements each cycle.
  - When it reaches 0: go to PULSE if rem!=0, else go to FIN.
- FIN:
  - done=1 for one cycle, busy=0. Next state is IDLE.
  - tgt_ready is 0 in FIN and returns to 1 in the following IDLE cycle.
- Latency:
  - A handshake accepted at cycle T gives the first inc_pulse at T+1.
  - Strobe k (k=1..N) occurs at T+1+(k-1)(GAP+1).
  - done occurs at T+1+N(GAP+1).
  - For rem==0, done occurs at T+1.
- Outputs are registered; no combinational path from inputs to inc_pulse.
- Wrap-around: the delay line only increments, so going "down" costs a wrap. Example: tap_cur=10, tgt_tap=3 gives 9 pulses; the final tap_cur is 3.
- tap_clr:
  - In IDLE: tap_cur<=0 next cycle.
  - Outside IDLE: tap_clr is ignored. Issuing tap_clr while busy is a caller error and is not corrected.
  - Simultaneous tap_clr and an accepted handshake in IDLE: clear first, then compute rem = tgt_tap - 0.
- tgt_valid while busy: held off by tgt_ready=0; tgt_tap is not sampled.
- Reset mid-sequence: immediate abort, outputs to their reset values, tap_cur=0. This matches the delay line sharing the same reset.

Optional Feature:
- Macro DELAY_TAP_CTRL_SWEEP_EN.
- When defined:
  - Adds input sweep_start and output tap_stb.
  - In IDLE, sweep_start (priority over tgt_valid when both are high) steps through all 2**TAP_W taps, i.e. 16 pulses, returning to the starting tap.
  - tap_stb=1 on the last cycle of each GAP, meaning the tap has settled and can be sampled.
  - done is raised after the 16th settle.
- When undefined: the ports are absent and behaviour is exactly as above.

Decomposition:
- Package delay_tap_pkg holds:
  - the FSM state enum (IDLE, PULSE, GAP, FIN)
  - TAP_W_DEF=4 and GAP_DEF=6
  - a mod-2**TAP_W tap-distance function
- One natural sub-module: delay_tap_gap_cnt, a loadable down-counter with a zero flag, used for the settle gap.

Test Plan:
- Reset then target 5 (GAP=6), starting from tap_cur=0 -> 5 inc_pulses at T+1, T+8, T+15, T+22, T+29; done at T+36; tap_cur=5.
- From tap 10, target 3 -> 9 pulses, tap_cur wraps through 15->0, final tap_cur=3, done at T+1+9*7.
- Target equal to tap_cur (7->7) -> no inc_pulse; done at T+1; tgt_ready low for one cycle only.
- tgt_valid held high with a new value during busy -> ignored until tgt_ready=1; the second target is then accepted and executed correctly.
- rst_n asserted after the 3rd pulse of an 8-pulse run -> inc_pulse and busy drop asynchronously and tap_cur=0. After release, target 2 yields exactly 2 pulses.
- tap_clr with tap_cur=9 in IDLE, then target 4 -> 4 pulses. With SWEEP_EN defined: sweep_start from tap 4 -> 16 pulses, 16 tap_stb, final tap_cur=4.

Source files
------------

// File: rtl/delay_tap_pkg.sv
// Shared types, defaults and helpers for the delay_tap_ctrl tap sequencer.
package delay_tap_pkg;

  localparam int TAP_W_DEF = 4;
  localparam int GAP_DEF   = 6;
  localparam int GAP_W     = 8;   // wide enough for the largest settle gap (255)
  localparam int MAX_TAP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_FIN
  } tap_state_e;

  // Forward distance on an increment-only ring: going "down" costs a wrap.
  function automatic logic [MAX_TAP_W-1:0] tap_dist(
    input logic [MAX_TAP_W-1:0] to_tap,
    input logic [MAX_TAP_W-1:0] from_tap,
    input int unsigned          tap_w
  );
    logic [MAX_TAP_W-1:0] mask;
    mask = MAX_TAP_W'((32'd1 << tap_w) - 32'd1);
    return (to_tap - from_tap) & mask;
  endfunction

endpackage

// File: rtl/delay_tap_gap_cnt.sv
// Loadable down-counter for the settle gap; flags the cycle on which it reaches zero.
module delay_tap_gap_cnt
  import delay_tap_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [GAP_W-1:0] i_load_val,
  output logic             o_zero_next
);

  logic [GAP_W-1:0] r_cnt;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - GAP_W'(1);
    end
  end

  assign o_zero_next = (r_cnt == GAP_W'(1));

endmodule

// File: rtl/delay_tap_ctrl.sv
// Increment-strobe sequencer for the var_delay15 delay line, with a shadow tap copy.
// Optional full-ring sweep with settle strobes when DELAY_TAP_CTRL_SWEEP_EN is defined.
module delay_tap_ctrl
  import delay_tap_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [TAP_W-1:0] tgt_tap,
  output logic             tgt_ready,
  input  logic             tap_clr,
  output logic             inc_pulse,
  output logic [TAP_W-1:0] tap_cur,
  output logic             busy,
`ifdef DELAY_TAP_CTRL_SWEEP_EN
  input  logic             sweep_start,
  output logic             tap_stb,
`endif
  output logic             done
);

  // One extra bit so a full sweep (2**TAP_W pulses) fits in the remaining count.
  localparam int REM_W = TAP_W + 1;

  tap_state_e       r_state;
  tap_state_e       w_state_nxt;
  logic [TAP_W-1:0] r_tap_cur;
  logic [TAP_W-1:0] w_tap_base;
  logic [REM_W-1:0] r_rem;
  logic [REM_W-1:0] w_rem_load;
  logic             w_start;
  logic             w_gap_last;
  logic             r_inc_pulse;
  logic             r_busy;
  logic             r_done;
  logic             r_tgt_ready;

  // A clear coinciding with a request applies first, so distance is measured from tap 0.
  assign w_tap_base = tap_clr ? '0 : r_tap_cur;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_start    = 1'b0;
    w_rem_load = REM_W'(tap_dist(MAX_TAP_W'(tgt_tap), MAX_TAP_W'(w_tap_base), TAP_W));
`ifdef DELAY_TAP_CTRL_SWEEP_EN
    if (sweep_start) begin
      w_start    = 1'b1;
      w_rem_load = REM_W'(1) << TAP_W;
    end else
`endif
    if (tgt_valid) begin
      w_start = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = (w_rem_load == '0) ? ST_FIN : ST_PULSE;
      ST_PULSE: w_state_nxt = ST_GAP;
      ST_GAP:   if (w_gap_last) w_state_nxt = (r_rem == '0) ? ST_FIN : ST_PULSE;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tap_cur   <= '0;
      r_rem       <= '0;
      r_inc_pulse <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tgt_ready <= 1'b1;
    end else begin
      r_inc_pulse <= (w_state_nxt == ST_PULSE);
      r_busy      <= (w_state_nxt == ST_PULSE) || (w_state_nxt == ST_GAP);
      r_done      <= (w_state_nxt == ST_FIN);
      r_tgt_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (tap_clr) r_tap_cur <= '0;
          if (w_start) r_rem <= w_rem_load;
        end
        ST_PULSE: begin
          r_tap_cur <= r_tap_cur + TAP_W'(1);
          r_rem     <= r_rem - REM_W'(1);
        end
        default: ;
      endcase
    end
  end

  delay_tap_gap_cnt u_gap_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (r_state == ST_PULSE),
    .i_load_val  (GAP_W'(GAP)),
    .o_zero_next (w_gap_last)
  );

`ifdef DELAY_TAP_CTRL_SWEEP_EN
  assign tap_stb = (r_state == ST_GAP) && w_gap_last;
`endif

  assign inc_pulse = r_inc_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
  assign tgt_ready = r_tgt_ready;
  assign tap_cur   = r_tap_cur;

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Self-checking bench for delay_tap_ctrl: directed plan plus randomized targets vs a timing model.
module tb_delay_tap_ctrl;

  localparam int TAP_W = 4;
  localparam int GAP   = 6;
  localparam int PER   = GAP + 1;
  localparam int NTAP  = 1 << TAP_W;
`ifdef DELAY_TAP_CTRL_SWEEP_EN
  localparam int VW = TAP_W + 5;
`else
  localparam int VW = TAP_W + 4;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             tgt_valid = 1'b0;
  logic [TAP_W-1:0] tgt_tap   = '0;
  logic             tap_clr   = 1'b0;
  logic             tgt_ready;
  logic             inc_pulse;
  logic [TAP_W-1:0] tap_cur;
  logic             busy;
  logic             done;
`ifdef DELAY_TAP_CTRL_SWEEP_EN
  logic             sweep_start = 1'b0;
  logic             tap_stb;
`endif

  int checks    = 0;
  int failures  = 0;
  int model_tap = 0;

  always #5 clk = ~clk;

  delay_tap_ctrl #(.TAP_W(TAP_W), .GAP(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tgt_valid   (tgt_valid),
    .tgt_tap     (tgt_tap),
    .tgt_ready   (tgt_ready),
    .tap_clr     (tap_clr),
    .inc_pulse   (inc_pulse),
    .tap_cur     (tap_cur),
    .busy        (busy),
`ifdef DELAY_TAP_CTRL_SWEEP_EN
    .sweep_start (sweep_start),
    .tap_stb     (tap_stb),
`endif
    .done        (done)
  );

  // Expected {inc_pulse, busy, done, tgt_ready, tap_cur[, tap_stb]} j cycles after acceptance
  // of a request needing n strobes from tap 'base'.
  function automatic logic [VW-1:0] exp_vec(input int base, input int n, input int j);
    int               fin;
    int               pulses;
    logic             p;
    logic [TAP_W-1:0] tap;
    fin    = 1 + n * PER;
    pulses = 0;
    for (int k = 1; k <= n; k++) if (1 + (k - 1) * PER < j) pulses++;
    p   = (j < fin) && ((j - 1) % PER == 0);
    tap = TAP_W'((base + pulses) % NTAP);
`ifdef DELAY_TAP_CTRL_SWEEP_EN
    return {p, j < fin, j == fin, j > fin, tap, (j < fin) && (j % PER == 0)};
`else
    return {p, j < fin, j == fin, j > fin, tap};
`endif
  endfunction

  function automatic logic [VW-1:0] obs_vec();
`ifdef DELAY_TAP_CTRL_SWEEP_EN
    return {inc_pulse, busy, done, tgt_ready, tap_cur, tap_stb};
`else
    return {inc_pulse, busy, done, tgt_ready, tap_cur};
`endif
  endfunction

  function automatic int fwd_dist(input int to_tap, input int from_tap);
    return ((to_tap - from_tap) % NTAP + NTAP) % NTAP;
  endfunction

  task automatic issue(input int tgt, input logic clr);
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_tap   = TAP_W'(tgt);
    tap_clr   = clr;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    tap_clr   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec(0, 0, 2)) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs_vec(), exp_vec(0, 0, 2));
    end
    model_tap = 0;
  endtask

  task automatic test_directed();
    int tgts [5] = '{5, 10, 3, 7, 7};
    int n;
    foreach (tgts[i]) begin
      n = fwd_dist(tgts[i], model_tap);
      issue(tgts[i], 1'b0);
      for (int j = 1; j <= n * PER + 2; j++) begin
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec(model_tap, n, j)) begin
          failures++;
          $display("FAIL directed tgt=%0d j=%0d got=%b exp=%b", tgts[i], j, obs_vec(),
                   exp_vec(model_tap, n, j));
        end
      end
      model_tap = tgts[i];
    end
  endtask

  task automatic test_tap_clr();
    int n;
    n = fwd_dist(9, model_tap);
    issue(9, 1'b0);
    for (int j = 1; j <= n * PER + 2; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec(model_tap, n, j)) begin
        failures++;
        $display("FAIL clr_setup j=%0d got=%b exp=%b", j, obs_vec(), exp_vec(model_tap, n, j));
      end
    end
    @(negedge clk);
    tap_clr = 1'b1;
    @(posedge clk);
    #1;
    tap_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec(0, 0, 2)) begin
      failures++;
      $display("FAIL clr_idle got=%b exp=%b", obs_vec(), exp_vec(0, 0, 2));
    end
    model_tap = 0;
    issue(4, 1'b0);
    for (int j = 1; j <= 4 * PER + 2; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec(0, 4, j)) begin
        failures++;
        $display("FAIL clr_then_4 j=%0d got=%b exp=%b", j, obs_vec(), exp_vec(0, 4, j));
      end
    end
    model_tap = 4;
  endtask

`ifdef DELAY_TAP_CTRL_SWEEP_EN
  task automatic test_sweep();
    int pulses = 0;
    int stbs   = 0;
    @(negedge clk);
    sweep_start = 1'b1;
    tgt_valid   = 1'b1;
    tgt_tap     = TAP_W'((model_tap + 3) % NTAP);
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    tgt_valid   = 1'b0;
    for (int j = 1; j <= NTAP * PER + 2; j++) begin
      @(negedge clk);
      pulses += int'(inc_pulse);
      stbs   += int'(tap_stb);
      checks++;
      if (obs_vec() !== exp_vec(model_tap, NTAP, j)) begin
        failures++;
        $display("FAIL sweep j=%0d got=%b exp=%b", j, obs_vec(), exp_vec(model_tap, NTAP, j));
      end
    end
    checks++;
    if (pulses != NTAP || stbs != NTAP || int'(tap_cur) != model_tap) begin
      failures++;
      $display("FAIL sweep_totals pulses=%0d stb=%0d tap=%0d exp %0d/%0d/%0d", pulses, stbs,
               tap_cur, NTAP, NTAP, model_tap);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int a, b, na, nb;
    a  = (model_tap + 8) % NTAP;
    b  = 2;
    na = fwd_dist(a, model_tap);
    nb = fwd_dist(b, a);
    issue(a, 1'b0);
    tgt_valid = 1'b1;
    tgt_tap   = TAP_W'(b);
    for (int j = 1; j <= na * PER + 2; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec(model_tap, na, j)) begin
        failures++;
        $display("FAIL b2b_first j=%0d got=%b exp=%b", j, obs_vec(), exp_vec(model_tap, na, j));
      end
    end
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    for (int j = 1; j <= nb * PER + 2; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec(a, nb, j)) begin
        failures++;
        $display("FAIL b2b_second j=%0d got=%b exp=%b", j, obs_vec(), exp_vec(a, nb, j));
      end
    end
    model_tap = b;
  endtask

  task automatic test_reset_abort();
    int tgt;
    tgt = (model_tap + 8) % NTAP;
    issue(tgt, 1'b0);
    for (int j = 1; j <= 1 + 3 * PER; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec(model_tap, 8, j)) begin
        failures++;
        $display("FAIL abort_run j=%0d got=%b exp=%b", j, obs_vec(), exp_vec(model_tap, 8, j));
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({inc_pulse, busy, done, tap_cur} !== {3'b000, TAP_W'(0)}) begin
      failures++;
      $display("FAIL abort_async got=%b exp=%b", {inc_pulse, busy, done, tap_cur},
               {3'b000, TAP_W'(0)});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    model_tap = 0;
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec(0, 0, 2)) begin
      failures++;
      $display("FAIL abort_idle got=%b exp=%b", obs_vec(), exp_vec(0, 0, 2));
    end
    issue(2, 1'b0);
    for (int j = 1; j <= 2 * PER + 2; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec(0, 2, j)) begin
        failures++;
        $display("FAIL abort_then_2 j=%0d got=%b exp=%b", j, obs_vec(), exp_vec(0, 2, j));
      end
    end
    model_tap = 2;
  endtask

  task automatic test_random();
    int   tgt, base, n;
    logic clr;
    for (int it = 0; it < 12; it++) begin
      tgt  = int'($urandom_range(0, NTAP - 1));
      clr  = ($urandom_range(0, 3) == 0);
      base = clr ? 0 : model_tap;
      n    = fwd_dist(tgt, base);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(tgt, clr);
      for (int j = 1; j <= n * PER + 2; j++) begin
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec(base, n, j)) begin
          failures++;
          $display("FAIL random it=%0d tgt=%0d clr=%0b j=%0d got=%b exp=%b", it, tgt, clr, j,
                   obs_vec(), exp_vec(base, n, j));
        end
      end
      model_tap = tgt;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_tap_clr();
`ifdef DELAY_TAP_CTRL_SWEEP_EN
    test_sweep();
`endif
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
